// File: rtl/pep_mmacc_splitc_feed_pkg.sv
// Shared constants for the MMACC split-C feed path: arithmetic geometry, modulus,
// CMUX pipeline latency and error-bit positions.
package pep_mmacc_splitc_feed_pkg;

   localparam int R              = 2;
   localparam int PSI            = 4;
   localparam int N              = 32;
   localparam int GLWE_K_P1      = 2;
   localparam int MOD_Q_W        = 64;
   localparam int BR_BATCH_CMD_W = 16;

   // Goldilocks prime 2^64 - 2^32 + 1
   localparam logic [MOD_Q_W-1:0] MOD_Q = 64'hFFFF_FFFF_0000_0001;

   localparam int MMACC_CMUX_LAT = 2;

   localparam int ERR_CMD_OVF = 0;
   localparam int ERR_CMD_UDF = 1;

endpackage

// File: rtl/pep_mmacc_splitc_cmux_sub.sv
// One-coefficient (rot - data) mod MOD_Q; stage 1 raw subtract, stage 2 correction.
// 2-cycle latency, no backpressure; registers only load on their stage's valid.
module pep_mmacc_splitc_cmux_sub
   import pep_mmacc_splitc_feed_pkg::*;
(
   input  logic               clk,
   input  logic               in_vld,
   input  logic               s1_vld,
   input  logic [MOD_Q_W-1:0] rot,
   input  logic [MOD_Q_W-1:0] data,
   output logic [MOD_Q_W-1:0] res
);

   logic [MOD_Q_W:0] s1_diff;

   always_ff @(posedge clk) begin
      if (in_vld) begin
         s1_diff <= {1'b0, rot} - {1'b0, data};
      end
   end

   // Sign bit set means rot < data; adding MOD_Q wraps back into [0, MOD_Q).
   always_ff @(posedge clk) begin
      if (s1_vld) begin
         res <= s1_diff[MOD_Q_W] ? (s1_diff[MOD_Q_W-1:0] + MOD_Q) : s1_diff[MOD_Q_W-1:0];
      end
   end

endmodule

// File: rtl/pep_mmacc_splitc_main_cmux.sv
// CMUX difference stage with batch-command FIFO and sop/eop/eob framing; 2-cycle latency.
// No backpressure: beats always accepted, overflowing commands dropped and flagged.
module pep_mmacc_splitc_main_cmux
   import pep_mmacc_splitc_feed_pkg::*;
#(
   parameter int HPSI           = PSI/2,
   parameter int BEAT_PER_POLY  = N/(R*PSI),
   parameter int POLY_PER_BATCH = GLWE_K_P1,
   parameter int CMD_DEPTH      = 4
)
(
   input  logic                           clk,
   input  logic                           a_rst_n,
   input  logic [HPSI*R*MOD_Q_W-1:0]      main_data,
   input  logic [HPSI*R*MOD_Q_W-1:0]      main_rot_data,
   input  logic                           main_data_avail,
   input  logic [BR_BATCH_CMD_W-1:0]      batch_cmd,
   input  logic                           batch_cmd_avail,
   output logic [HPSI*R*MOD_Q_W-1:0]      cmux_data,
   output logic                           cmux_avail,
   output logic                           cmux_sop,
   output logic                           cmux_eop,
   output logic                           cmux_eob,
   output logic [BR_BATCH_CMD_W-1:0]      cmux_batch_cmd,
   output logic [1:0]                     error
);

   localparam int LANES = HPSI*R;
   localparam int BW    = (BEAT_PER_POLY  > 1) ? $clog2(BEAT_PER_POLY)  : 1;
   localparam int PW    = (POLY_PER_BATCH > 1) ? $clog2(POLY_PER_BATCH) : 1;
   localparam int AW    = (CMD_DEPTH      > 1) ? $clog2(CMD_DEPTH)      : 1;
   localparam int CW    = $clog2(CMD_DEPTH+1);

   localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_PER_POLY-1);
   localparam logic [PW-1:0] POLY_LAST = PW'(POLY_PER_BATCH-1);
   localparam logic [AW-1:0] PTR_LAST  = AW'(CMD_DEPTH-1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(CMD_DEPTH);

   logic [BR_BATCH_CMD_W-1:0] fifo_mem [CMD_DEPTH];
   logic [AW-1:0]             wr_ptr;
   logic [AW-1:0]             rd_ptr;
   logic [CW-1:0]             fifo_cnt;
   logic [BW-1:0]             beat_cnt;
   logic [PW-1:0]             poly_cnt;

   logic                      fifo_empty;
   logic                      fifo_full;
   logic                      has_cmd;
   logic [BR_BATCH_CMD_W-1:0] head_cmd;
   logic                      in_sop;
   logic                      in_eop;
   logic                      in_eob;
   logic                      do_pop;
   logic                      do_push;
   logic                      cmd_ovf;
   logic                      cmd_udf;

   logic                      s1_vld;
   logic                      s1_sop;
   logic                      s1_eop;
   logic                      s1_eob;
   logic                      s1_udf;
   logic [BR_BATCH_CMD_W-1:0] s1_cmd;
   logic [BR_BATCH_CMD_W-1:0] s2_cmd;
   logic                      out_udf;
   logic                      out_ovf;

   // An empty FIFO forwards a same-cycle push so a batch may start with its command.
   always_comb begin
      fifo_empty = (fifo_cnt == '0);
      fifo_full  = (fifo_cnt == CNT_FULL);
      has_cmd    = !fifo_empty || batch_cmd_avail;
      head_cmd   = '0;
      if (!fifo_empty) begin
         head_cmd = fifo_mem[rd_ptr];
      end else if (batch_cmd_avail) begin
         head_cmd = batch_cmd;
      end
      in_sop  = (beat_cnt == '0);
      in_eop  = (beat_cnt == BEAT_LAST);
      in_eob  = in_eop && (poly_cnt == POLY_LAST);
      do_pop  = main_data_avail && in_eob && has_cmd;
      do_push = batch_cmd_avail && (!fifo_full || do_pop);
      cmd_ovf = batch_cmd_avail && fifo_full && !do_pop;
      cmd_udf = main_data_avail && !has_cmd;
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         fifo_mem[wr_ptr] <= batch_cmd;
      end
   end

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         beat_cnt <= '0;
         poly_cnt <= '0;
      end else if (main_data_avail) begin
         if (in_eop) begin
            beat_cnt <= '0;
            poly_cnt <= in_eob ? '0 : poly_cnt + PW'(1);
         end else begin
            beat_cnt <= beat_cnt + BW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         s1_vld     <= 1'b0;
         s1_sop     <= 1'b0;
         s1_eop     <= 1'b0;
         s1_eob     <= 1'b0;
         s1_udf     <= 1'b0;
         cmux_avail <= 1'b0;
         cmux_sop   <= 1'b0;
         cmux_eop   <= 1'b0;
         cmux_eob   <= 1'b0;
         out_udf    <= 1'b0;
         out_ovf    <= 1'b0;
      end else begin
         s1_vld     <= main_data_avail;
         s1_sop     <= main_data_avail && in_sop;
         s1_eop     <= main_data_avail && in_eop;
         s1_eob     <= main_data_avail && in_eob;
         s1_udf     <= cmd_udf;
         cmux_avail <= s1_vld;
         cmux_sop   <= s1_vld && s1_sop;
         cmux_eop   <= s1_vld && s1_eop;
         cmux_eob   <= s1_vld && s1_eob;
         out_udf    <= s1_vld && s1_udf;
         out_ovf    <= cmd_ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (main_data_avail) begin
         s1_cmd <= head_cmd;
      end
      if (s1_vld) begin
         s2_cmd <= s1_cmd;
      end
   end

   assign cmux_batch_cmd = cmux_avail ? s2_cmd : '0;

   // Overflow reports at the push; underflow travels with its beat.
   always_comb begin
      error              = '0;
      error[ERR_CMD_OVF] = out_ovf;
      error[ERR_CMD_UDF] = out_udf;
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      pep_mmacc_splitc_cmux_sub u_sub (
         .clk    (clk),
         .in_vld (main_data_avail),
         .s1_vld (s1_vld),
         .rot    (main_rot_data[gi*MOD_Q_W +: MOD_Q_W]),
         .data   (main_data[gi*MOD_Q_W +: MOD_Q_W]),
         .res    (cmux_data[gi*MOD_Q_W +: MOD_Q_W])
      );
   end

endmodule

// File: tb/tb_pep_mmacc_splitc_main_cmux.sv
// Directed bench: reference model of batch framing, command queue and modular
// difference, compared against the CMUX outputs every cycle, plus literal pins.
module tb_pep_mmacc_splitc_main_cmux;
   import pep_mmacc_splitc_feed_pkg::*;

   localparam int BPP   = 4;
   localparam int PPB   = 2;
   localparam int DEPTH = 4;
   localparam int LANES = 4;
   localparam int DW    = LANES*64;
   localparam logic [63:0] Q = 64'hFFFF_FFFF_0000_0001;

   typedef struct packed {
      logic          avail;
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
      logic          eob;
      logic          udf;
      logic [15:0]   cmd;
   } rec_t;

   logic          clk;
   logic          a_rst_n;
   logic [DW-1:0] main_data;
   logic [DW-1:0] main_rot_data;
   logic          main_data_avail;
   logic [15:0]   batch_cmd;
   logic          batch_cmd_avail;
   logic [DW-1:0] cmux_data;
   logic          cmux_avail;
   logic          cmux_sop;
   logic          cmux_eop;
   logic          cmux_eob;
   logic [15:0]   cmux_batch_cmd;
   logic [1:0]    error;

   pep_mmacc_splitc_main_cmux #(
      .HPSI(2), .BEAT_PER_POLY(BPP), .POLY_PER_BATCH(PPB), .CMD_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .a_rst_n(a_rst_n),
      .main_data(main_data), .main_rot_data(main_rot_data), .main_data_avail(main_data_avail),
      .batch_cmd(batch_cmd), .batch_cmd_avail(batch_cmd_avail),
      .cmux_data(cmux_data), .cmux_avail(cmux_avail), .cmux_sop(cmux_sop),
      .cmux_eop(cmux_eop), .cmux_eob(cmux_eob), .cmux_batch_cmd(cmux_batch_cmd),
      .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          nvec = 0;
   int          nerr = 0;
   int          cyc  = 0;
   int          m_idx = 0;
   logic [15:0] mq[$];
   rec_t        exp_at[int];
   bit          err0_at[int];
   int          sop_seen = 0;
   int          eop_seen = 0;
   int          eob_seen = 0;
   logic [15:0] eob_cmds[$];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      nvec++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
      end
   endtask

   function automatic logic [63:0] modsub(input logic [63:0] r, input logic [63:0] d);
      return (r >= d) ? (r - d) : (r + (Q - d));
   endfunction

   task automatic model_clear();
      exp_at.delete();
      err0_at.delete();
      mq.delete();
      m_idx = 0;
   endtask

   // Batch position is an index 0..BPP*PPB-1; the queue is the command FIFO.
   task automatic model_step(input logic dav, input logic [63:0] r0, input logic [63:0] d0,
                             input logic cav, input logic [15:0] cmd);
      rec_t e;
      bit   pop;
      bit   ovf;
      bit   consumed;
      int   bpos;
      pop      = 0;
      consumed = 0;
      if (dav) begin
         e       = '0;
         e.avail = 1'b1;
         bpos    = m_idx % BPP;
         e.sop   = (bpos == 0);
         e.eop   = (bpos == BPP-1);
         e.eob   = (m_idx == BPP*PPB-1);
         if (mq.size() > 0)  e.cmd = mq[0];
         else if (cav)       e.cmd = cmd;
         else begin
            e.cmd = '0;
            e.udf = 1'b1;
         end
         for (int i = 0; i < LANES; i++) begin
            e.data[i*64 +: 64] = modsub(r0 + 64'(i), d0 + 64'(2*i));
         end
         exp_at[cyc+2] = e;
         pop   = e.eob && !e.udf;
         m_idx = e.eob ? 0 : m_idx + 1;
      end
      ovf = cav && (mq.size() == DEPTH) && !pop;
      if (pop) begin
         if (mq.size() > 0) mq.delete(0);
         else               consumed = 1;
      end
      if (cav && !ovf && !consumed) mq.push_back(cmd);
      if (ovf) err0_at[cyc+1] = 1'b1;
   endtask

   task automatic compare();
      rec_t e;
      bit   e0;
      e = '0;
      if (exp_at.exists(cyc)) begin
         e = exp_at[cyc];
         exp_at.delete(cyc);
      end
      e0 = err0_at.exists(cyc) ? 1'b1 : 1'b0;
      if (e0) err0_at.delete(cyc);
      chk("avail",   DW'(cmux_avail),     DW'(e.avail));
      chk("sop",     DW'(cmux_sop),       DW'(e.sop));
      chk("eop",     DW'(cmux_eop),       DW'(e.eop));
      chk("eob",     DW'(cmux_eob),       DW'(e.eob));
      chk("cmd",     DW'(cmux_batch_cmd), DW'(e.cmd));
      chk("err_udf", DW'(error[1]),       DW'(e.udf));
      chk("err_ovf", DW'(error[0]),       DW'(e0));
      if (e.avail) chk("data", cmux_data, e.data);
      if (cmux_sop) sop_seen++;
      if (cmux_eop) eop_seen++;
      if (cmux_eob) begin
         eob_seen++;
         eob_cmds.push_back(cmux_batch_cmd);
      end
   endtask

   task automatic tick(input logic dav, input logic [63:0] r0, input logic [63:0] d0,
                       input logic cav, input logic [15:0] cmd);
      main_data_avail = dav;
      batch_cmd_avail = cav;
      batch_cmd       = cmd;
      for (int i = 0; i < LANES; i++) begin
         main_rot_data[i*64 +: 64] = r0 + 64'(i);
         main_data[i*64 +: 64]     = d0 + 64'(2*i);
      end
      model_step(dav, r0, d0, cav, cmd);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      compare();
   endtask

   task automatic beat(input logic [63:0] r0, input logic [63:0] d0);
      tick(1'b1, r0, d0, 1'b0, 16'h0);
   endtask

   task automatic push(input logic [15:0] cmd);
      tick(1'b0, 64'h0, 64'h0, 1'b1, cmd);
   endtask

   task automatic idle();
      tick(1'b0, 64'h0, 64'h0, 1'b0, 16'h0);
   endtask

   function automatic logic [63:0] vr(input int k);
      return (k % 2 == 1) ? (Q - 64'(30 + k)) : 64'(k * 4099);
   endfunction

   function automatic logic [63:0] vd(input int k);
      return (k % 3 == 0) ? (Q - 64'(50 + k)) : 64'(k * 7919 + 11);
   endfunction

   initial begin
      a_rst_n         = 1'b1;
      main_data       = '0;
      main_rot_data   = '0;
      main_data_avail = 1'b0;
      batch_cmd       = '0;
      batch_cmd_avail = 1'b0;
      #2 a_rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_avail", DW'(cmux_avail),     DW'(0));
      chk("rst_sop",   DW'(cmux_sop),       DW'(0));
      chk("rst_eop",   DW'(cmux_eop),       DW'(0));
      chk("rst_eob",   DW'(cmux_eob),       DW'(0));
      chk("rst_cmd",   DW'(cmux_batch_cmd), DW'(0));
      chk("rst_error", DW'(error),          DW'(0));
      a_rst_n = 1'b1;

      // Latency and modular difference, then one full batch of 8 beats.
      push(16'h00A1);
      beat(64'd5, 64'd7);
      chk("lat_not_yet", DW'(cmux_avail), DW'(0));
      beat(64'd7, 64'd5);
      chk("lit_avail",   DW'(cmux_avail), DW'(1));
      chk("lit_neg",     DW'(cmux_data[63:0]), DW'(64'hFFFF_FFFE_FFFF_FFFF));
      chk("lit_sop0",    DW'(cmux_sop), DW'(1));
      chk("lit_cmd_a1",  DW'(cmux_batch_cmd), DW'(16'h00A1));
      for (int k = 2; k < 8; k++) begin
         beat(vr(k), vd(k));
         if (k == 2) chk("lit_pos", DW'(cmux_data[63:0]), DW'(2));
      end
      idle();
      idle();
      chk("lit_sop_cnt", DW'(sop_seen), DW'(2));
      chk("lit_eop_cnt", DW'(eop_seen), DW'(2));
      chk("lit_eob_cnt", DW'(eob_seen), DW'(1));

      // Beats with no command: flagged, still framed, no pop.
      beat(64'd100, 64'd40);
      idle();
      chk("lit_udf",      DW'(error[1]),       DW'(1));
      chk("lit_udf_cmd",  DW'(cmux_batch_cmd), DW'(0));
      chk("lit_udf_sop",  DW'(cmux_sop),       DW'(1));
      chk("lit_udf_data", DW'(cmux_data[63:0]), DW'(60));
      beat(64'd1, 64'd2);
      idle();
      chk("lit_udf2_sop",  DW'(cmux_sop), DW'(0));
      chk("lit_udf2_data", DW'(cmux_data[63:0]), DW'(64'hFFFF_FFFF_0000_0000));
      for (int k = 0; k < 6; k++) beat(vr(k + 10), vd(k + 10));
      idle();
      idle();

      // Overflow on the fifth command; the first four drain in order.
      eob_cmds.delete();
      for (int k = 1; k <= 5; k++) push(16'hC000 + 16'(k));
      chk("lit_ovf", DW'(error[0]), DW'(1));
      for (int k = 0; k < 32; k++) beat(vr(k + 20), vd(k + 20));
      idle();
      idle();
      chk("lit_drain_n", DW'(eob_cmds.size()), DW'(4));
      for (int k = 0; k < 4 && k < eob_cmds.size(); k++)
         chk("lit_drain_cmd", DW'(eob_cmds[k]), DW'(16'hC001 + 16'(k)));

      // Full FIFO: pop and push in one cycle keep it full without error.
      eob_cmds.delete();
      for (int k = 1; k <= 4; k++) push(16'hD000 + 16'(k));
      for (int k = 0; k < 7; k++) beat(vr(k + 60), vd(k + 60));
      tick(1'b1, vr(67), vd(67), 1'b1, 16'hD005);
      chk("lit_full_swap_noerr", DW'(error[0]), DW'(0));
      push(16'hD006);
      chk("lit_still_full", DW'(error[0]), DW'(1));
      for (int k = 0; k < 32; k++) beat(vr(k + 70), vd(k + 70));
      idle();
      idle();
      chk("lit_swap_n", DW'(eob_cmds.size()), DW'(5));
      for (int k = 0; k < 5 && k < eob_cmds.size(); k++)
         chk("lit_swap_cmd", DW'(eob_cmds[k]), DW'(16'hD001 + 16'(k)));

      // Reset mid-batch discards in-flight beats and restarts framing.
      push(16'h00E1);
      beat(vr(3), vd(3));
      beat(vr(4), vd(4));
      main_data_avail = 1'b0;
      batch_cmd_avail = 1'b0;
      a_rst_n = 1'b0;
      #1;
      chk("lit_rst_avail", DW'(cmux_avail),     DW'(0));
      chk("lit_rst_sop",   DW'(cmux_sop),       DW'(0));
      chk("lit_rst_cmd",   DW'(cmux_batch_cmd), DW'(0));
      chk("lit_rst_err",   DW'(error),          DW'(0));
      model_clear();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("lit_rst_hold", DW'(cmux_avail), DW'(0));
      a_rst_n = 1'b1;
      tick(1'b1, 64'd9, 64'd4, 1'b1, 16'h00E2);
      idle();
      chk("lit_post_sop",  DW'(cmux_sop),       DW'(1));
      chk("lit_bypass",    DW'(cmux_batch_cmd), DW'(16'h00E2));
      chk("lit_post_err",  DW'(error),          DW'(0));
      chk("lit_post_data", DW'(cmux_data[63:0]), DW'(5));
      for (int k = 0; k < 7; k++) beat(vr(k + 110), vd(k + 110));
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/pep_mmacc_splitc_main_cmux.md
PEP_MMACC_SPLITC_MAIN_CMUX -- requirements
Module: pep_mmacc_splitc_main_cmux

Interface
REQ-001 SHALL have parameter HPSI, default PSI/2: number of PSI lanes in the main data path.
REQ-002 SHALL have parameter BEAT_PER_POLY, default N/(R*PSI): input beats per polynomial.
REQ-003 SHALL have parameter POLY_PER_BATCH, default GLWE_K_P1: polynomials per batch command.
REQ-004 SHALL have parameter CMD_DEPTH, default 4: batch-command FIFO depth.
REQ-005 SHALL have the ports clk, in, 1: clock; a_rst_n, in, 1: reset, asynchronous and active-low (one clock; reset is asynchronous and active-low).
REQ-006 SHALL have the ports main_data, in, HPSI*R*MOD_Q_W: unrotated coefficients; main_rot_data, in, HPSI*R*MOD_Q_W: rotated coefficients; main_data_avail, in, 1: beat strobe, no backpressure.
REQ-007 SHALL have the ports batch_cmd, in, BR_BATCH_CMD_W: batch descriptor; batch_cmd_avail, in, 1: descriptor strobe.
REQ-008 SHALL have the ports cmux_data, out, HPSI*R*MOD_Q_W: (rot - data) mod MOD_Q; cmux_avail, out, 1; cmux_sop, out, 1; cmux_eop, out, 1; cmux_eob, out, 1; cmux_batch_cmd, out, BR_BATCH_CMD_W.
REQ-009 SHALL have the ports error, out, 2: bit0 command FIFO overflow, bit1 data beat without command (underflow).

Function
REQ-010 SHALL compute per coefficient d = rot - data over MOD_Q_W+1 bits, then add MOD_Q when the result is negative; both operands are in [0, MOD_Q).
REQ-011 SHALL register the subtraction in stage 1 and the correction in stage 2: cmux_avail rises exactly 2 cycles after main_data_avail, and all cmux_* fields are aligned to it.
REQ-012 SHALL push batch_cmd into a CMD_DEPTH FIFO on batch_cmd_avail; the head of the FIFO is the current batch.
REQ-013 SHALL maintain beat_cnt (0..BEAT_PER_POLY-1) and poly_cnt (0..POLY_PER_BATCH-1), both advanced on main_data_avail.
REQ-014 SHALL set sop when beat_cnt==0, eop when beat_cnt==BEAT_PER_POLY-1, and eob when eop holds and poly_cnt==POLY_PER_BATCH-1.
REQ-015 SHALL wrap beat_cnt to 0 at eop and increment poly_cnt; at eob SHALL wrap poly_cnt to 0 and pop the command FIFO.
REQ-016 SHALL output on cmux_batch_cmd the FIFO head sampled at input time, piped through both stages.
REQ-017 SHALL allow push and pop in the same cycle while the FIFO is full: pop-then-push, no overflow.
REQ-018 SHALL, when batch_cmd_avail arrives with the FIFO full and no pop in that cycle, drop the command and pulse error[0] for 1 cycle.
REQ-019 SHALL, when main_data_avail arrives with the FIFO empty and no same-cycle push, still process the data, output cmux_batch_cmd='0, pulse error[1] with the beat, and skip the pop at eob.
REQ-020 SHALL, when the FIFO is empty and a push and a data beat occur in the same cycle, use the pushed command as head (bypass).
REQ-021 SHALL drive all outputs to 0 when cmux_avail=0, except cmux_data, which holds its last value.
REQ-022 SHALL keep error as a pulse, not sticky; the sticky error register lives in the regif.

Reset
REQ-023 SHALL, on a_rst_n low, immediately clear: FIFO pointers/count, beat_cnt, poly_cnt, pipeline avail bits, error, cmux_sop/eop/eob, and cmux_avail.
REQ-024 SHALL not reset the data-path registers (cmux_data, pipelined batch_cmd).
REQ-025 SHALL discard in-flight beats on reset mid-batch; the first beat after release is treated as sop of poly 0.

Structure
REQ-026 SHALL place the MMACC_CMUX_LAT=2 constant and the error bit indices in pep_mmacc_splitc_feed_pkg.
REQ-027 SHALL implement the modular subtractor in sub-module pep_mmacc_splitc_cmux_sub (one coefficient, 2-stage); the top instantiates HPSI*R copies.
REQ-028 SHALL implement the command FIFO inline; the total is 120-400 lines.

Verification
REQ-029 SHALL verify, with MOD_Q=2^64-2^32+1: rot=5, data=7 -> cmux_data = MOD_Q-2, avail 2 cycles later; rot=7, data=5 -> 2.
REQ-030 SHALL verify, with BEAT_PER_POLY=4 and POLY_PER_BATCH=2, 1 command then 8 back-to-back beats -> sop on beats 0 and 4, eop on beats 3 and 7, eob on beat 7 only, FIFO empty afterwards.
REQ-031 SHALL verify 5 commands pushed with no data and CMD_DEPTH=4 -> error[0] on the 5th; commands 1-4 are then output in order across 4 batches.
REQ-032 SHALL verify a data beat with the FIFO empty -> error[1] pulse, cmux_batch_cmd=0, counters still advance.
REQ-033 SHALL verify a full FIFO with eob and batch_cmd_avail in the same cycle -> no error, count stays 4.
REQ-034 SHALL verify a_rst_n asserted after 2 of 4 beats -> outputs 0 at once; after release, the next beat flags sop.
